ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline, between the ID/EX boundary and the memory stage.
- Registers the ID-to-EX bus and computes the ALU result.
- Drives the data SRAM request (enable, byte write-enables, address, write data) and produces the EX-to-MEM bus and the EX forwarding bus.
- Owns the HI/LO registers and a multi-cycle radix-2 divider; asserts a stall request while the divider is busy.

---
 rtl/ex_stage_pkg.sv | 52 +++++
 rtl/ex_div.sv | 86 ++++++++
 rtl/ex_stage.sv | 151 +++++++++++++++
 tb/tb_ex_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage slice: bus widths, opcode
// encodings, stall-vector polarity and the divider state type.
// Optional feature macro: EX_MULT_EN (MULT / MULTU into HI/LO).
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int StallBus     = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [3:0] ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] ALU_OP_SUB  = 4'h1;
  localparam logic [3:0] ALU_OP_SLT  = 4'h2;
  localparam logic [3:0] ALU_OP_SLTU = 4'h3;
  localparam logic [3:0] ALU_OP_AND  = 4'h4;
  localparam logic [3:0] ALU_OP_OR   = 4'h5;
  localparam logic [3:0] ALU_OP_XOR  = 4'h6;
  localparam logic [3:0] ALU_OP_NOR  = 4'h7;
  localparam logic [3:0] ALU_OP_SLL  = 4'h8;
  localparam logic [3:0] ALU_OP_SRL  = 4'h9;
  localparam logic [3:0] ALU_OP_SRA  = 4'hA;
  localparam logic [3:0] ALU_OP_LUI  = 4'hB;
  localparam logic [3:0] ALU_OP_MFHI = 4'hC;
  localparam logic [3:0] ALU_OP_MFLO = 4'hD;
  localparam logic [3:0] ALU_OP_PASS = 4'hE;

  localparam logic [2:0] MEM_OP_NONE = 3'd0;
  localparam logic [2:0] MEM_OP_LW   = 3'd1;
  localparam logic [2:0] MEM_OP_SW   = 3'd2;
  localparam logic [2:0] MEM_OP_SH   = 3'd3;
  localparam logic [2:0] MEM_OP_SB   = 3'd4;

  localparam logic [1:0] DIV_OP_NONE = 2'd0;
  localparam logic [1:0] DIV_OP_DIV  = 2'd1;
  localparam logic [1:0] DIV_OP_DIVU = 2'd2;
  localparam logic [1:0] DIV_OP_MULT = 2'd3;

  localparam logic [1:0] HILO_OP_NONE  = 2'd0;
  localparam logic [1:0] HILO_OP_MTHI  = 2'd1;
  localparam logic [1:0] HILO_OP_MTLO  = 2'd2;
  localparam logic [1:0] HILO_OP_MULTU = 2'd3;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider (one quotient bit per cycle).
// Ports: clk, rst (sync, active-high); start, is_signed, dividend, divisor;
// busy (iterating), done (one-cycle result valid), quotient, remainder.
// Divisor 0 yields quotient all-ones and remainder equal to the dividend.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  div_state_t  state, next_state;
  logic [CW-1:0] cnt;
  logic [31:0] rem_r, dq_r, dvs_r;
  logic        neg_q, neg_r;
  logic [33:0] trial;

  // Partial remainder shifted left by one quotient bit, minus the divisor;
  // bit 33 set means the subtraction must be undone (restoring step).
  assign trial = {1'b0, rem_r, dq_r[31]} - {2'b00, dvs_r};

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE: if (start) next_state = DIV_BUSY;
      DIV_BUSY: if (cnt == CW'(DIV_CYCLES - 1)) next_state = DIV_DONE;
      DIV_DONE: next_state = DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV_BUSY);
    done = (state == DIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem_r <= '0;
      dq_r  <= '0;
      dvs_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == DIV_IDLE) begin
      if (start) begin
        cnt   <= '0;
        rem_r <= '0;
        dq_r  <= is_signed ? abs32(dividend) : dividend;
        dvs_r <= is_signed ? abs32(divisor) : divisor;
        // Divide-by-zero keeps the all-ones quotient unsigned-looking.
        neg_q <= is_signed & (dividend[31] ^ divisor[31]) & (divisor != '0);
        neg_r <= is_signed & dividend[31];
      end
    end else if (state == DIV_BUSY) begin
      cnt <= cnt + CW'(1);
      if (!trial[33]) begin
        rem_r <= trial[31:0];
        dq_r  <= {dq_r[30:0], 1'b1};
      end else begin
        rem_r <= {rem_r[30:0], dq_r[31]};
        dq_r  <= {dq_r[30:0], 1'b0};
      end
    end
  end

  assign quotient  = neg_q ? (~dq_r + 32'd1) : dq_r;
  assign remainder = neg_r ? (~rem_r + 32'd1) : rem_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers the ID-to-EX bus, computes the ALU result,
// drives the data SRAM request, owns HI/LO and the divider.
// Ports: clk, rst (sync, active-high), stall[5:0], id_to_ex_bus[158:0];
// ex_to_mem_bus[75:0], ex_to_id_bus[37:0], ex_is_load, stallreq_for_ex,
// data_sram_en/wen/addr/wdata.
// Optional macro EX_MULT_EN: div_op=3 MULT, hilo_op=3 MULTU into {HI,LO}.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);
  logic [ID_TO_EX_WD-1:0] id_to_ex_r;
  logic        ex_load;

  logic [31:0] pc, src1, src2, store_data, ex_result, hi, lo;
  logic [3:0]  alu_op;
  logic [2:0]  mem_op;
  logic [1:0]  div_op, hilo_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;

  logic        div_req, div_served, div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic        unused_ok;

  assign ex_load = (stall[2] == NoStop) || (stall[3] == NoStop);

  always_ff @(posedge clk) begin
    if (rst)                                       id_to_ex_r <= '0;
    else if (stall[2] == Stop && stall[3] == NoStop) id_to_ex_r <= '0;
    else if (stall[2] == NoStop)                   id_to_ex_r <= id_to_ex_bus;
  end

  assign {pc, alu_op, src1, src2, store_data, mem_op, div_op, hilo_op,
          rf_we, rf_waddr} = id_to_ex_r[158:14];
  assign unused_ok = ^{id_to_ex_r[13:0], stall[5:4], stall[1:0], div_busy};

  always_comb begin
    ex_result = '0;
    case (alu_op)
      ALU_OP_ADD:  ex_result = src1 + src2;
      ALU_OP_SUB:  ex_result = src1 - src2;
      ALU_OP_SLT:  ex_result = {31'd0, $signed(src1) < $signed(src2)};
      ALU_OP_SLTU: ex_result = {31'd0, src1 < src2};
      ALU_OP_AND:  ex_result = src1 & src2;
      ALU_OP_OR:   ex_result = src1 | src2;
      ALU_OP_XOR:  ex_result = src1 ^ src2;
      ALU_OP_NOR:  ex_result = ~(src1 | src2);
      ALU_OP_SLL:  ex_result = src2 << src1[4:0];
      ALU_OP_SRL:  ex_result = src2 >> src1[4:0];
      ALU_OP_SRA:  ex_result = $unsigned($signed(src2) >>> src1[4:0]);
      ALU_OP_LUI:  ex_result = {src2[15:0], 16'd0};
      ALU_OP_MFHI: ex_result = hi;
      ALU_OP_MFLO: ex_result = lo;
      ALU_OP_PASS: ex_result = src1;
      default:     ex_result = '0;
    endcase
  end

  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_wdata = '0;
    case (mem_op)
      MEM_OP_LW: data_sram_en = 1'b1;
      MEM_OP_SW: begin
        data_sram_en    = 1'b1;
        data_sram_wen   = '1;
        data_sram_wdata = store_data;
      end
      MEM_OP_SH: begin
        data_sram_en    = 1'b1;
        data_sram_wen   = ex_result[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{store_data[15:0]}};
      end
      MEM_OP_SB: begin
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b0001 << ex_result[1:0];
        data_sram_wdata = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign data_sram_addr = ex_result;
  assign ex_is_load     = (mem_op == MEM_OP_LW);
  assign ex_to_mem_bus  = {pc, data_sram_en, data_sram_wen, ex_is_load,
                           rf_we, rf_waddr, ex_result};
  assign ex_to_id_bus   = {rf_we, rf_waddr, ex_result};

  assign div_req         = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_DIVU);
  assign stallreq_for_ex = div_req && !div_served && !div_done;

  ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_req && !div_served),
    .is_signed (div_op == DIV_OP_DIV),
    .dividend  (src1),
    .divisor   (src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Any EX load retires the divide; otherwise a completed divide is marked
  // served so a held instruction does not restart it.
  always_ff @(posedge clk) begin
    if (rst)           div_served <= 1'b0;
    else if (ex_load)  div_served <= 1'b0;
    else if (div_done) div_served <= 1'b1;
  end

`ifdef EX_MULT_EN
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
  assign prod_u = {32'd0, src1} * {32'd0, src2};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done) begin
      hi <= div_r;
      lo <= div_q;
    end else if (stall[2] == NoStop) begin
      if (hilo_op == HILO_OP_MTHI) hi <= src1;
      if (hilo_op == HILO_OP_MTLO) lo <= src1;
`ifdef EX_MULT_EN
      if (div_op == DIV_OP_MULT)        {hi, lo} <= prod_s;
      else if (hilo_op == HILO_OP_MULTU) {hi, lo} <= prod_u;
`endif
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall_tb;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         ex_is_load, stallreq_for_ex, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Pipeline control model: a divider stall request holds IF..EX and MEM.
  assign stall = stall_tb | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [3:0] alu,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] sd, input logic [2:0] mem,
                                      input logic [1:0] dv, input logic [1:0] hl,
                                      input logic we, input logic [4:0] wa);
    return {pc, alu, s1, s2, sd, mem, dv, hl, we, wa, 14'd0};
  endfunction

  function automatic logic [75:0] mem_bus(input logic [31:0] pc, input logic en,
                                          input logic [3:0] wen, input logic sel,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] res);
    return {pc, en, wen, sel, we, wa, res};
  endfunction

  // Called at a negedge; the instruction is in EX at the following negedge.
  task automatic step_in(input logic [158:0] b);
    id_to_ex_bus = b;
    @(negedge clk);
    id_to_ex_bus = '0;
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    step_in(mk(32'h0, op, a, b, 32'h0, 3'd0, 2'd0, 2'd0, 1'b0, 5'd0));
    check_val(tag, ex_to_mem_bus[31:0], exp);
  endtask

  // Issue a divide, count stall-request cycles (bounded), read LO then HI.
  task automatic div_chk(input string tag, input logic [1:0] dv, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int n;
    step_in(mk(32'h0, 4'h0, a, b, 32'h0, 3'd0, dv, 2'd0, 1'b0, 5'd0));
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_val({tag, "_stallcyc"}, n, 33);
    step_in(mk(32'h0, 4'hD, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd2));
    check_val({tag, "_lo"}, ex_to_mem_bus[31:0], exp_lo);
    step_in(mk(32'h0, 4'hC, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd3));
    check_val({tag, "_hi"}, ex_to_mem_bus[31:0], exp_hi);
  endtask

  initial begin
    rst = 1'b1;
    stall_tb = '0;
    id_to_ex_bus = '0;
    repeat (3) @(negedge clk);
    check_val("rst_mem_bus", ex_to_mem_bus, 76'd0);
    check_val("rst_sram", {data_sram_en, data_sram_wen, stallreq_for_ex}, 6'd0);
    rst = 1'b0;

    // ADD wraps; forwarding bus reflects the same cycle
    step_in(mk(32'h1000, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd5));
    check_val("add_mem_bus", ex_to_mem_bus,
              mem_bus(32'h1000, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd5, 32'h80000000));
    check_val("add_fwd", ex_to_id_bus, {1'b1, 5'd5, 32'h80000000});

    alu_chk("sub",  4'h1, 32'd3, 32'd5, 32'hFFFFFFFE);
    alu_chk("slt",  4'h2, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu_chk("sltu", 4'h3, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu_chk("sra",  4'hA, 32'd4, 32'h80000000, 32'hF8000000);
    alu_chk("srl",  4'h9, 32'd4, 32'h80000000, 32'h08000000);
    alu_chk("sll",  4'h8, 32'd31, 32'h3, 32'h80000000);
    alu_chk("lui",  4'hB, 32'h0, 32'h00001234, 32'h12340000);
    alu_chk("nor",  4'h7, 32'h0F0F0000, 32'h0000F0F0, 32'hF0F00F0F);
    alu_chk("rsvd", 4'hF, 32'h12345678, 32'h1, 32'h0);

    // Stores and load
    step_in(mk(32'h2000, 4'h0, 32'h100, 32'h3, 32'h000000A5, 3'd4, 2'd0, 2'd0, 1'b0, 5'd0));
    check_val("sb_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
              {1'b1, 4'b1000, 32'h103, 32'hA5A5A5A5});
    step_in(mk(32'h2004, 4'h0, 32'h100, 32'h2, 32'h1234BEEF, 3'd3, 2'd0, 2'd0, 1'b0, 5'd0));
    check_val("sh_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
              {1'b1, 4'b1100, 32'h102, 32'hBEEFBEEF});
    step_in(mk(32'h2008, 4'h0, 32'h200, 32'h4, 32'h0, 3'd1, 2'd0, 2'd0, 1'b1, 5'd9));
    check_val("lw_req", {data_sram_en, data_sram_wen, ex_is_load, ex_to_mem_bus[38]},
              {1'b1, 4'b0000, 1'b1, 1'b1});

    // Held SW repeats its write; then a bubble is inserted
    step_in(mk(32'h3000, 4'h0, 32'h200, 32'h0, 32'hDEADBEEF, 3'd2, 2'd0, 2'd0, 1'b0, 5'd0));
    check_val("sw_req", {data_sram_wen, data_sram_addr, data_sram_wdata},
              {4'b1111, 32'h200, 32'hDEADBEEF});
    stall_tb = 6'b001100;
    id_to_ex_bus = mk(32'h3004, 4'h0, 32'h1, 32'h1, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd1);
    repeat (2) @(negedge clk);
    check_val("sw_hold", ex_to_mem_bus,
              mem_bus(32'h3000, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 32'h200));
    check_val("sw_hold_wdata", data_sram_wdata, 32'hDEADBEEF);
    stall_tb = 6'b000100;
    #1;
    check_val("sw_bubble_cyc", ex_to_mem_bus,
              mem_bus(32'h3000, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 32'h200));
    @(negedge clk);
    check_val("bubble", ex_to_mem_bus, 76'd0);
    stall_tb = '0;
    id_to_ex_bus = '0;

    // Divider
    div_chk("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd14, 32'd2);
    div_chk("div_m7_2", 2'd1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    div_chk("divu_by0", 2'd2, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    div_chk("div_by0", 2'd1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0);
    div_chk("div_ovf", 2'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);

    // MTHI / MTLO then immediate read
    step_in(mk(32'h0, 4'h0, 32'h0000CAFE, 32'h0, 32'h0, 3'd0, 2'd0, 2'd1, 1'b0, 5'd0));
    step_in(mk(32'h0, 4'hC, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd4));
    check_val("mthi_mfhi", ex_to_mem_bus[31:0], 32'h0000CAFE);
    step_in(mk(32'h0, 4'h0, 32'h00000055, 32'h0, 32'h0, 3'd0, 2'd0, 2'd2, 1'b0, 5'd0));
    step_in(mk(32'h0, 4'hD, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd4));
    check_val("mtlo_mflo", ex_to_mem_bus[31:0], 32'h00000055);

    // div_op=3: MULT when enabled, otherwise no effect and no stall
    step_in(mk(32'h0, 4'h0, 32'hFFFFFFFE, 32'd3, 32'h0, 3'd0, 2'd3, 2'd0, 1'b0, 5'd0));
    check_val("mult_nostall", stallreq_for_ex, 1'b0);
    step_in(mk(32'h0, 4'hD, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd4));
`ifdef EX_MULT_EN
    check_val("mult_lo", ex_to_mem_bus[31:0], 32'hFFFFFFFA);
`else
    check_val("mult_lo", ex_to_mem_bus[31:0], 32'h00000055);
`endif

    // Reset during a divide
    step_in(mk(32'h4000, 4'h0, 32'hFFFFFF00, 32'd3, 32'h0, 3'd0, 2'd1, 2'd0, 1'b1, 5'd7));
    repeat (9) @(negedge clk);
    check_val("div_busy_mid", stallreq_for_ex, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_stallreq", stallreq_for_ex, 1'b0);
    check_val("rst_mid_bus", ex_to_mem_bus, 76'd0);
    step_in(mk(32'h0, 4'hC, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd4));
    check_val("rst_mid_hi", ex_to_mem_bus[31:0], 32'h0);
    step_in(mk(32'h0, 4'hD, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 2'd0, 1'b1, 5'd4));
    check_val("rst_mid_lo", ex_to_mem_bus[31:0], 32'h0);
    div_chk("divu_after_rst", 2'd2, 32'd1000, 32'd10, 32'd100, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
